// File: rtl/flash_spi_reader_if.sv
// Request/response channel between the SoC fetch logic and flash_spi_reader.
interface flash_spi_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        req_dual;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_addr, req_dual,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_dual,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/flash_spi_reader.sv
// SPI mode-0 flash word reader (READ 0x03) driving the chip_io flash pads.
// Optional dual-output read (0x3B) is enabled with `define FLASH_DUAL_READ_EN.
module flash_spi_reader #(
  parameter int DIV     = 2,
  parameter int CS_IDLE = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               enable,
  flash_spi_reader_if.slave  bus,
  output logic               flash_csb_core,
  output logic               flash_clk_core,
  output logic               flash_csb_oeb_core,
  output logic               flash_clk_oeb_core,
  output logic               flash_io0_oeb_core,
  output logic               flash_io1_oeb_core,
  output logic               flash_io0_ieb_core,
  output logic               flash_io1_ieb_core,
  output logic               flash_io0_do_core,
  output logic               flash_io1_do_core,
  input  logic               flash_io0_di_core,
  input  logic               flash_io1_di_core
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP
  } state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   div_cnt;
  logic            half;
  logic [4:0]      bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [31:0]     tx_sr;
  logic [31:0]     rx_sr;
  logic [31:0]     rsp_data;
  logic            rsp_valid;
  logic            dual;
  logic            own;
  logic            active;
  logic            bit_end;
  logic            accept;
  logic            phase_end;
  logic            ready;
  logic [4:0]      data_last;
  logic [7:0]      cmd;
  logic            dual_sel;

  function automatic logic [31:0] byte_order(input logic [31:0] s);
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

`ifdef FLASH_DUAL_READ_EN
  assign dual_sel = bus.req_dual;
`else
  logic unused_req_dual;
  assign unused_req_dual = bus.req_dual;
  assign dual_sel        = 1'b0;
`endif

  assign cmd       = dual_sel ? 8'h3B : 8'h03;
  assign active    = (state == S_CMD) || (state == S_ADDR) ||
                     (state == S_DUMMY) || (state == S_DATA);
  assign bit_end   = (div_cnt == DIV_LAST) && half;
  assign data_last = dual ? 5'd15 : 5'd31;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    phase_end = 1'b0;
    ready     = (state == S_IDLE) && enable && own && (gap_cnt == GAP_LAST);
    case (state)
      S_IDLE:  if (bus.req_valid && ready) begin
                 accept   = 1'b1;
                 state_nx = S_CMD;
               end
      S_CMD:   if (bit_end && bit_cnt == 5'd7) begin
                 phase_end = 1'b1;
                 state_nx  = S_ADDR;
               end
      S_ADDR:  if (bit_end && bit_cnt == 5'd23) begin
                 phase_end = 1'b1;
                 state_nx  = dual ? S_DUMMY : S_DATA;
               end
      S_DUMMY: if (bit_end && bit_cnt == 5'd7) begin
                 phase_end = 1'b1;
                 state_nx  = S_DATA;
               end
      S_DATA:  if (bit_end && bit_cnt == data_last) begin
                 phase_end = 1'b1;
                 state_nx  = S_GAP;
               end
      S_GAP:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bit timing: DIV cycles SCK low, DIV cycles high; MOSI shifts at the fall,
  // MISO is captured on the clock edge that raises SCK.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      div_cnt   <= '0;
      half      <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      dual      <= 1'b0;
      own       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == S_IDLE) own <= enable;
      if ((state == S_IDLE || state == S_GAP) && gap_cnt != GAP_LAST)
        gap_cnt <= gap_cnt + 1'b1;
      if (accept) begin
        tx_sr   <= {cmd, bus.req_addr};
        dual    <= dual_sel;
        div_cnt <= '0;
        half    <= 1'b0;
        bit_cnt <= '0;
        gap_cnt <= '0;
      end else if (active) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          half    <= ~half;
          if (!half) begin
            if (state == S_DATA)
              rx_sr <= dual ? {rx_sr[29:0], flash_io1_di_core, flash_io0_di_core}
                            : {rx_sr[30:0], flash_io1_di_core};
          end else begin
            bit_cnt <= phase_end ? 5'd0 : bit_cnt + 5'd1;
            if (state == S_CMD || state == S_ADDR) tx_sr <= {tx_sr[30:0], 1'b0};
            if (state == S_DATA && phase_end) begin
              rsp_data  <= byte_order(rx_sr);
              rsp_valid <= 1'b1;
            end
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  // Pad ownership follows own, which only tracks enable while idle.
  assign flash_csb_core     = ~active;
  assign flash_clk_core     = active & half;
  assign flash_csb_oeb_core = ~own;
  assign flash_clk_oeb_core = ~own;
  assign flash_io0_oeb_core = ~own | (state == S_DUMMY) | (state == S_DATA);
  assign flash_io1_oeb_core = 1'b1;
  assign flash_io0_ieb_core = ~(own & dual & (state == S_DATA));
  assign flash_io1_ieb_core = ~own;
  assign flash_io0_do_core  = tx_sr[31];
  assign flash_io1_do_core  = 1'b0;

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;

endmodule
